// File: rtl/x_top.sv
// x_top: PS/2-keyboard hex calculator with a 16-entry register file,
// a multiplexed 4-digit seven-segment display and an 8-bit GPO port.
module x_regf #(
    parameter int DATA_W      = 32,
    parameter int REGF_ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [5:0][DATA_W-1:0] wdata,
    output logic [5:0][DATA_W-1:0] rdata
);
    localparam int N = 2 ** REGF_ADDR_W;
    logic [DATA_W-1:0] reg_1 [0:N-1];
    always_ff @(posedge clk) begin
        for (int k = 0; k < 6; k++)
            if (rst) reg_1[k] <= '0;
            else if (we) reg_1[k] <= wdata[k];
        for (int k = 6; k < N; k++)
            reg_1[k] <= '0;
    end
    for (genvar g = 0; g < 6; g++) assign rdata[g] = reg_1[g];
endmodule

module x_top #(
    parameter int DATA_W      = 32,
    parameter int REGF_ADDR_W = 4,
    parameter int REFRESH_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic        push_AC,
    output logic        push_C,
    output logic [11:0] disp_ctrl,
    output logic [7:0]  gpo_out
);
    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} rx_state_t;
    rx_state_t state;
    logic [1:0] clk_sync, dat_sync;
    logic clk_prev, fall, par, rx_valid, make;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [4:0] hex;
    logic [DATA_W-1:0] applied;
    logic [5:0][DATA_W-1:0] cur, nxt;
    logic [REFRESH_W-1:0] refresh;
    logic [1:0] sel;
    logic [15:0] shown;
    logic [3:0] nib;

    function automatic logic [4:0] hex_of(input logic [7:0] c);
        case (c)
            8'h45: return 5'h10;  8'h16: return 5'h11;  8'h1E: return 5'h12;  8'h26: return 5'h13;
            8'h25: return 5'h14;  8'h2E: return 5'h15;  8'h36: return 5'h16;  8'h3D: return 5'h17;
            8'h3E: return 5'h18;  8'h46: return 5'h19;  8'h1C: return 5'h1A;  8'h32: return 5'h1B;
            8'h21: return 5'h1C;  8'h23: return 5'h1D;  8'h24: return 5'h1E;  8'h2B: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    assign fall = clk_prev & ~clk_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
            state    <= IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            par      <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_prev <= clk_sync[1];
            rx_valid <= 1'b0;
            if (fall)
                case (state)
                    IDLE: if (!dat_sync[1]) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        shift   <= {dat_sync[1], shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PAR;
                    end
                    PAR: begin
                        par   <= dat_sync[1];
                        state <= STOP;
                    end
                    default: begin
                        rx_valid <= dat_sync[1] & ^{shift, par};
                        state    <= IDLE;
                    end
                endcase
        end
    end

    // r0 = {.., show_acc, prefix_E0, prefix_F0}; a byte following F0 is a break code
    always_comb begin
        nxt     = cur;
        make    = 1'b0;
        hex     = hex_of(shift);
        applied = cur[3] == DATA_W'(1) ? cur[2] + cur[1] : cur[3] == DATA_W'(2) ? cur[2] - cur[1] : cur[1];
        if (cur[0][0]) nxt[0][1:0] = 2'b00;
        else if (shift == 8'hF0) nxt[0][1:0] = 2'b01;
        else if (shift == 8'hE0) nxt[0][1:0] = 2'b10;
        else begin
            make        = 1'b1;
            nxt[0][1:0] = 2'b00;
            nxt[4]      = DATA_W'(shift);
            nxt[5]      = cur[5] + DATA_W'(1);
            if (hex[4]) begin
                nxt[1]    = {cur[1][DATA_W-5:0], hex[3:0]};
                nxt[0][2] = 1'b0;
            end else if (shift == 8'h79 || shift == 8'h7B || shift == 8'h5A) begin
                nxt[2]    = applied;
                nxt[3]    = shift == 8'h79 ? DATA_W'(1) : shift == 8'h7B ? DATA_W'(2) : '0;
                nxt[1]    = '0;
                nxt[0][2] = 1'b1;
            end else if (shift == 8'h76) begin
                nxt[0] = '0;
                nxt[1] = '0;
                nxt[2] = '0;
                nxt[3] = '0;
            end else if (shift == 8'h66) begin
                nxt[1]    = '0;
                nxt[0][2] = 1'b0;
            end
        end
    end

    x_regf #(.DATA_W(DATA_W), .REGF_ADDR_W(REGF_ADDR_W)) regf (
        .clk   (clk),
        .rst   (rst),
        .we    (rx_valid),
        .wdata (nxt),
        .rdata (cur)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            push_AC <= 1'b0;
            push_C  <= 1'b0;
            refresh <= '0;
        end else begin
            push_AC <= rx_valid & make & (shift == 8'h76);
            push_C  <= rx_valid & make & (shift == 8'h66);
            refresh <= refresh + 1'b1;
        end
    end

    assign sel       = refresh[REFRESH_W-1 -: 2];
    assign shown     = cur[0][2] ? cur[2][15:0] : cur[1][15:0];
    assign nib       = shown[{sel, 2'b00} +: 4];
    assign disp_ctrl = {~(4'b0001 << sel), seg_of(nib)};
    assign gpo_out   = cur[4][7:0];
endmodule

// File: tb/tb_x_top.sv
// tb_x_top: randomized self-checking bench for the PS/2 hex calculator
// against a behavioural calculator model.
module tb_x_top;
    localparam int RW   = 8;
    localparam int HALF = 10;
    localparam int DWELL = 2 ** (RW - 2);

    logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic push_AC, push_C;
    logic [11:0] disp_ctrl;
    logic [7:0] gpo_out;
    int n_chk = 0, n_fail = 0, ac_cnt = 0, c_cnt = 0;

    logic [7:0] codes [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                               8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
    logic [7:0] seg_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    bit m_pf0, m_e0, m_sa;
    logic [31:0] m_entry, m_acc, m_op, m_last, m_cnt;

    x_top #(.DATA_W(32), .REGF_ADDR_W(4), .REFRESH_W(RW)) uut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .push_AC   (push_AC),
        .push_C    (push_C),
        .disp_ctrl (disp_ctrl),
        .gpo_out   (gpo_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (push_AC) ac_cnt++;
        if (push_C) c_cnt++;
    end

    task automatic model_clear();
        m_pf0 = 0; m_e0 = 0; m_sa = 0;
        m_entry = 0; m_acc = 0; m_op = 0; m_last = 0; m_cnt = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int d;
        d = -1;
        for (int i = 0; i < 16; i++) if (codes[i] == b) d = i;
        if (m_pf0) begin m_pf0 = 0; m_e0 = 0; end
        else if (b == 8'hF0) begin m_pf0 = 1; m_e0 = 0; end
        else if (b == 8'hE0) m_e0 = 1;
        else begin
            m_e0 = 0;
            m_last = {24'b0, b};
            m_cnt = m_cnt + 1;
            if (d >= 0) begin
                m_entry = m_entry * 16 + 32'(d);
                m_sa = 0;
            end else if (b == 8'h79 || b == 8'h7B || b == 8'h5A) begin
                if (m_op == 1) m_acc = m_acc + m_entry;
                else if (m_op == 2) m_acc = m_acc - m_entry;
                else m_acc = m_entry;
                m_op = (b == 8'h79) ? 1 : (b == 8'h7B) ? 2 : 0;
                m_entry = 0;
                m_sa = 1;
            end else if (b == 8'h76) begin
                m_pf0 = 0; m_e0 = 0; m_sa = 0; m_entry = 0; m_acc = 0; m_op = 0;
            end else if (b == 8'h66) begin
                m_entry = 0;
                m_sa = 0;
            end
        end
    endtask

    function automatic logic [31:0] exp_reg(input int k);
        case (k)
            0: return {29'b0, m_sa, m_e0, m_pf0};
            1: return m_entry;
            2: return m_acc;
            3: return m_op;
            4: return m_last;
            5: return m_cnt;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [11:0] exp_disp(input int i);
        logic [15:0] v;
        v = m_sa ? m_acc[15:0] : m_entry[15:0];
        return {~(4'b0001 << i), seg_lut[(v >> (4 * i)) % 16]};
    endfunction

    task automatic do_reset();
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic ps2_fall(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
    endtask

    task automatic ps2_rise();
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_fall(f[i]);
            ps2_rise();
        end
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_key(input logic [7:0] b);
        send_frame(b, 0, 0);
        model_byte(b);
    endtask

    task automatic wait_digit(input int i, output bit ok);
        ok = 0;
        for (int c = 0; c < 4 * DWELL + 8 && !ok; c++) begin
            @(negedge clk);
            ok = disp_ctrl[11:8] == ~(4'b0001 << i);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (disp_ctrl !== 12'hEC0) begin n_fail++; $display("FAIL reset_disp: got %h expected %h", disp_ctrl, 12'hEC0); end
        n_chk++;
        if (gpo_out !== 8'h00) begin n_fail++; $display("FAIL reset_gpo: got %h expected 00", gpo_out); end
        n_chk++;
        if ({push_AC, push_C} !== 2'b00) begin n_fail++; $display("FAIL reset_push: got %b expected 00", {push_AC, push_C}); end
        for (int k = 0; k < 16; k++) begin
            n_chk++;
            if (uut.regf.reg_1[k] !== 32'h0) begin n_fail++; $display("FAIL reset_r%0d: got %h expected 0", k, uut.regf.reg_1[k]); end
        end
    endtask

    task automatic test_idle();
        bit ok;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            ps2_fall(1'b1);
            ps2_rise();
        end
        for (int k = 0; k < 6; k++) begin
            n_chk++;
            if (uut.regf.reg_1[k] !== 32'h0) begin n_fail++; $display("FAIL idle_r%0d: got %h expected 0", k, uut.regf.reg_1[k]); end
        end
        n_chk++;
        if (gpo_out !== 8'h00) begin n_fail++; $display("FAIL idle_gpo: got %h expected 00", gpo_out); end
        for (int i = 0; i < 4; i++) begin
            wait_digit(i, ok);
            n_chk++;
            if (!ok || disp_ctrl !== {~(4'b0001 << i), 8'hC0}) begin
                n_fail++; $display("FAIL idle_digit%0d: got %h expected %h", i, disp_ctrl, {~(4'b0001 << i), 8'hC0});
            end
        end
    endtask

    task automatic test_basic();
        bit ok;
        do_reset();
        send_key(8'h16); send_key(8'hF0); send_key(8'h16); send_key(8'h1E);
        n_chk++;
        if (uut.regf.reg_1[1] !== 32'h12) begin n_fail++; $display("FAIL basic_entry: got %h expected 12", uut.regf.reg_1[1]); end
        n_chk++;
        if (uut.regf.reg_1[5] !== 32'd2) begin n_fail++; $display("FAIL basic_count: got %0d expected 2", uut.regf.reg_1[5]); end
        n_chk++;
        if (uut.regf.reg_1[0] !== 32'h0) begin n_fail++; $display("FAIL basic_status: got %h expected 0", uut.regf.reg_1[0]); end
        n_chk++;
        if (gpo_out !== 8'h1E) begin n_fail++; $display("FAIL basic_gpo: got %h expected 1E", gpo_out); end
        wait_digit(1, ok);
        n_chk++;
        if (!ok || disp_ctrl !== 12'hDF9) begin n_fail++; $display("FAIL basic_digit1: got %h expected DF9", disp_ctrl); end
        wait_digit(0, ok);
        n_chk++;
        if (!ok || disp_ctrl !== 12'hEA4) begin n_fail++; $display("FAIL basic_digit0: got %h expected EA4", disp_ctrl); end
    endtask

    task automatic test_arith();
        bit ok;
        do_reset();
        send_key(8'h2E); send_key(8'h79); send_key(8'h26); send_key(8'h5A);
        n_chk++;
        if (uut.regf.reg_1[2] !== 32'd8) begin n_fail++; $display("FAIL add_acc: got %h expected 8", uut.regf.reg_1[2]); end
        n_chk++;
        if (uut.regf.reg_1[3] !== 32'd0) begin n_fail++; $display("FAIL add_op: got %h expected 0", uut.regf.reg_1[3]); end
        n_chk++;
        if (uut.regf.reg_1[0] !== 32'h4) begin n_fail++; $display("FAIL add_show_acc: got %h expected 4", uut.regf.reg_1[0]); end
        wait_digit(0, ok);
        n_chk++;
        if (!ok || disp_ctrl !== 12'hE80) begin n_fail++; $display("FAIL add_digit0: got %h expected E80", disp_ctrl); end
        do_reset();
        send_key(8'h1E); send_key(8'h7B);
        n_chk++;
        if (uut.regf.reg_1[3] !== 32'd2) begin n_fail++; $display("FAIL sub_pending: got %h expected 2", uut.regf.reg_1[3]); end
        send_key(8'h26); send_key(8'h5A);
        n_chk++;
        if (uut.regf.reg_1[2] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL sub_acc: got %h expected FFFFFFFF", uut.regf.reg_1[2]); end
        for (int i = 0; i < 4; i++) begin
            wait_digit(i, ok);
            n_chk++;
            if (!ok || disp_ctrl !== {~(4'b0001 << i), 8'h8E}) begin
                n_fail++; $display("FAIL sub_digit%0d: got %h expected %h", i, disp_ctrl, {~(4'b0001 << i), 8'h8E});
            end
        end
    endtask

    task automatic test_clear();
        int ac0, c0;
        send_key(8'h25);
        ac0 = ac_cnt; c0 = c_cnt;
        send_key(8'h66);
        n_chk++;
        if (c_cnt - c0 !== 1 || ac_cnt - ac0 !== 0) begin
            n_fail++; $display("FAIL clear_c_pulse: got C=%0d AC=%0d cycles expected 1 0", c_cnt - c0, ac_cnt - ac0);
        end
        n_chk++;
        if (uut.regf.reg_1[1] !== 32'h0 || uut.regf.reg_1[0] !== 32'h0) begin
            n_fail++; $display("FAIL clear_c_regs: got r0=%h r1=%h expected 0 0", uut.regf.reg_1[0], uut.regf.reg_1[1]);
        end
        ac0 = ac_cnt; c0 = c_cnt;
        send_key(8'h76);
        n_chk++;
        if (ac_cnt - ac0 !== 1 || c_cnt - c0 !== 0) begin
            n_fail++; $display("FAIL clear_ac_pulse: got AC=%0d C=%0d cycles expected 1 0", ac_cnt - ac0, c_cnt - c0);
        end
        for (int k = 0; k < 6; k++) begin
            n_chk++;
            if (uut.regf.reg_1[k] !== exp_reg(k)) begin n_fail++; $display("FAIL clear_ac_r%0d: got %h expected %h", k, uut.regf.reg_1[k], exp_reg(k)); end
        end
    endtask

    task automatic test_bad_frames();
        do_reset();
        send_key(8'h16);
        send_frame(8'h1E, 1, 0);
        for (int k = 0; k < 6; k++) begin
            n_chk++;
            if (uut.regf.reg_1[k] !== exp_reg(k)) begin n_fail++; $display("FAIL badpar_r%0d: got %h expected %h", k, uut.regf.reg_1[k], exp_reg(k)); end
        end
        send_frame(8'h1E, 0, 1);
        for (int k = 0; k < 6; k++) begin
            n_chk++;
            if (uut.regf.reg_1[k] !== exp_reg(k)) begin n_fail++; $display("FAIL badstop_r%0d: got %h expected %h", k, uut.regf.reg_1[k], exp_reg(k)); end
        end
        send_key(8'h26);
        n_chk++;
        if (uut.regf.reg_1[1] !== 32'h13 || uut.regf.reg_1[5] !== 32'd2) begin
            n_fail++; $display("FAIL bad_recover: got r1=%h r5=%0d expected 13 2", uut.regf.reg_1[1], uut.regf.reg_1[5]);
        end
    endtask

    task automatic test_latency();
        logic [10:0] f;
        do_reset();
        f = {1'b1, ~^8'h45, 8'h45, 1'b0};
        for (int i = 0; i < 10; i++) begin
            ps2_fall(f[i]);
            ps2_rise();
        end
        ps2_fall(1'b1);
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (uut.regf.reg_1[5] !== 32'd0) begin n_fail++; $display("FAIL latency_early: got r5=%0d expected 0", uut.regf.reg_1[5]); end
        @(posedge clk);
        #1;
        n_chk++;
        if (uut.regf.reg_1[5] !== 32'd1 || uut.regf.reg_1[4] !== 32'h45) begin
            n_fail++; $display("FAIL latency_write: got r5=%0d r4=%h expected 1 45", uut.regf.reg_1[5], uut.regf.reg_1[4]);
        end
        ps2_rise();
        ps2_data = 1'b1;
        model_byte(8'h45);
        repeat (20) @(negedge clk);
    endtask

    task automatic test_dwell();
        logic [3:0] an;
        int len;
        bit ok;
        an = disp_ctrl[11:8];
        ok = 0;
        for (int c = 0; c < 2 * DWELL && !ok; c++) begin @(negedge clk); ok = disp_ctrl[11:8] != an; end
        an = disp_ctrl[11:8];
        len = 0;
        while (ok && disp_ctrl[11:8] == an && len < 2 * DWELL) begin @(negedge clk); len++; end
        n_chk++;
        if (!ok || len != DWELL) begin n_fail++; $display("FAIL dwell: got %0d cycles expected %0d", len, DWELL); end
    endtask

    task automatic test_midreset();
        do_reset();
        send_key(8'h16);
        for (int i = 0; i < 5; i++) begin
            ps2_fall(i == 0 ? 1'b0 : 1'b1);
            ps2_rise();
        end
        do_reset();
        n_chk++;
        if (uut.regf.reg_1[5] !== 32'd0 || uut.regf.reg_1[1] !== 32'h0) begin
            n_fail++; $display("FAIL midreset_clear: got r1=%h r5=%0d expected 0 0", uut.regf.reg_1[1], uut.regf.reg_1[5]);
        end
        send_key(8'h1E);
        n_chk++;
        if (uut.regf.reg_1[1] !== 32'h2 || uut.regf.reg_1[5] !== 32'd1) begin
            n_fail++; $display("FAIL midreset_next: got r1=%h r5=%0d expected 2 1", uut.regf.reg_1[1], uut.regf.reg_1[5]);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit ok;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: b = codes[$urandom_range(0, 15)];
                5: b = $urandom_range(0, 1) ? 8'h79 : 8'h7B;
                6: b = 8'h5A;
                7: b = $urandom_range(0, 1) ? 8'hF0 : 8'hE0;
                8: b = ($urandom_range(0, 3) == 0) ? 8'h76 : 8'h66;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send_key(b);
            for (int k = 0; k < 6; k++) begin
                n_chk++;
                if (uut.regf.reg_1[k] !== exp_reg(k)) begin
                    n_fail++; $display("FAIL rand_r%0d (key %0d=%h): got %h expected %h", k, n, b, uut.regf.reg_1[k], exp_reg(k));
                end
            end
            n_chk++;
            if (gpo_out !== m_last[7:0]) begin n_fail++; $display("FAIL rand_gpo: got %h expected %h", gpo_out, m_last[7:0]); end
        end
        for (int k = 6; k < 16; k++) begin
            n_chk++;
            if (uut.regf.reg_1[k] !== 32'h0) begin n_fail++; $display("FAIL rand_reserved_r%0d: got %h expected 0", k, uut.regf.reg_1[k]); end
        end
        for (int i = 0; i < 4; i++) begin
            wait_digit(i, ok);
            n_chk++;
            if (!ok || disp_ctrl !== exp_disp(i)) begin n_fail++; $display("FAIL rand_digit%0d: got %h expected %h", i, disp_ctrl, exp_disp(i)); end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_basic();
        test_arith();
        test_clear();
        test_bad_frames();
        test_latency();
        test_dwell();
        test_midreset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
